// File: rtl/npu_dma_pkg.sv
// npu_dma_pkg: shared FSM type and sizing helpers for the 2D strided read DMA
package npu_dma_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, REQ, DRAIN} state_t;
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction
  function automatic logic [15:0] min_burst(input logic [15:0] max_burst, input logic [15:0] rem);
    return (rem < max_burst) ? rem : max_burst;
  endfunction
endpackage

// File: rtl/npu_sync_fifo.sv
// npu_sync_fifo: show-ahead synchronous FIFO with occupancy count and flush
module npu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count_q != (AW+1)'(DEPTH) || do_pop);
  assign dout = mem[rd_q];
  assign count = count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q] <= din;
endmodule

// File: rtl/npu_dma_rd2d.sv
// npu_dma_rd2d: credit-gated 2D strided Avalon-MM read DMA with tagged output stream and abort
module npu_dma_rd2d
  import npu_dma_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int BURST_W    = $clog2(MAX_BURST) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cfg_addr,
  input  logic [15:0]        cfg_row_len,
  input  logic [15:0]        cfg_rows,
  input  logic [31:0]        cfg_stride,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  input  logic               m_waitrequest,
  input  logic [DATA_W-1:0]  m_readdata,
  input  logic               m_readdatavalid,
  output logic [31:0]        m_address,
  output logic [BURST_W-1:0] m_burstcount,
  output logic               m_read,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_row_last,
  output logic               out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] BPW = 32'(bytes_per_word(DATA_W));
  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, aborted_q, aborted_d, abort_q, abort_d;
  logic m_read_q, m_read_d;
  logic [31:0] m_address_q, m_address_d, addr_q, addr_d, row_base_q, row_base_d, stride_q, stride_d;
  logic [BURST_W-1:0] m_burstcount_q, m_burstcount_d;
  logic [15:0] row_rem_q, row_rem_d, rows_rem_q, rows_rem_d, row_len_q, row_len_d, rows_q, rows_d;
  logic [15:0] rx_col_q, rx_col_d, rx_row_q, rx_row_d;
  logic [CW-1:0] pending_q, pending_d, fifo_count, free;
  logic [CW:0] used;
  logic [15:0] burst;
  logic ab, beat, grant, row_last, last_tag, fifo_empty;
  assign burst = min_burst(16'(MAX_BURST), row_rem_q);
  assign used = {1'b0, fifo_count} + {1'b0, pending_q};
  assign free = (used >= (CW+1)'(FIFO_DEPTH)) ? '0 : CW'((CW+1)'(FIFO_DEPTH) - used);
  assign ab = abort_q | (busy_q & abort);
  assign beat = m_readdatavalid & busy_q;
  assign grant = m_read_q & ~m_waitrequest;
  assign row_last = rx_col_q == row_len_q - 16'd1;
  assign last_tag = row_last && rx_row_q == rows_q - 16'd1;
  npu_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(ab),
    .push(beat & ~ab),
    .din({last_tag, row_last, m_readdata}),
    .pop(out_ready),
    .dout({out_last, out_row_last, out_data}),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign out_valid = ~fifo_empty;
  assign busy = busy_q;
  assign done = done_q;
  assign aborted = aborted_q;
  assign m_read = m_read_q;
  assign m_address = m_address_q;
  assign m_burstcount = m_burstcount_q;
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    done_d = 1'b0;
    aborted_d = aborted_q;
    abort_d = ab;
    m_read_d = m_read_q;
    m_address_d = m_address_q;
    m_burstcount_d = m_burstcount_q;
    addr_d = addr_q;
    row_base_d = row_base_q;
    stride_d = stride_q;
    row_rem_d = row_rem_q;
    rows_rem_d = rows_rem_q;
    row_len_d = row_len_q;
    rows_d = rows_q;
    pending_d = pending_q + (grant ? CW'(m_burstcount_q) : '0) - (beat ? CW'(1) : '0);
    rx_col_d = beat ? (row_last ? 16'd0 : rx_col_q + 16'd1) : rx_col_q;
    rx_row_d = (beat && row_last) ? rx_row_q + 16'd1 : rx_row_q;
    case (state_q)
      IDLE: if (start && !done_q) begin
        row_len_d = cfg_row_len;
        rows_d = cfg_rows;
        stride_d = cfg_stride;
        addr_d = cfg_addr;
        row_base_d = cfg_addr;
        row_rem_d = cfg_row_len;
        rows_rem_d = cfg_rows;
        rx_col_d = '0;
        rx_row_d = '0;
        aborted_d = 1'b0;
        abort_d = 1'b0;
        busy_d = 1'b1;
        state_d = (cfg_rows == '0 || cfg_row_len == '0) ? DRAIN : ISSUE;
      end
      ISSUE: if (ab) state_d = DRAIN;
      else if (16'(free) >= burst) begin
        m_read_d = 1'b1;
        m_address_d = addr_q;
        m_burstcount_d = BURST_W'(burst);
        state_d = REQ;
      end
      REQ: if (grant) begin
        m_read_d = 1'b0;
        row_rem_d = row_rem_q - 16'(m_burstcount_q);
        addr_d = addr_q + 32'(m_burstcount_q) * BPW;
        if (row_rem_d == '0) begin
          rows_rem_d = rows_rem_q - 16'd1;
          row_base_d = row_base_q + stride_q;
          addr_d = row_base_q + stride_q;
          row_rem_d = row_len_q;
        end
        m_address_d = addr_d;
        state_d = (ab || rows_rem_d == '0) ? DRAIN : ISSUE;
      end
      DRAIN: if (pending_q == '0 && fifo_empty) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        aborted_d = ab;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      aborted_q <= 1'b0;
      abort_q <= 1'b0;
      m_read_q <= 1'b0;
      m_address_q <= '0;
      m_burstcount_q <= '0;
      addr_q <= '0;
      row_base_q <= '0;
      stride_q <= '0;
      row_rem_q <= '0;
      rows_rem_q <= '0;
      row_len_q <= '0;
      rows_q <= '0;
      pending_q <= '0;
      rx_col_q <= '0;
      rx_row_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      done_q <= done_d;
      aborted_q <= aborted_d;
      abort_q <= abort_d;
      m_read_q <= m_read_d;
      m_address_q <= m_address_d;
      m_burstcount_q <= m_burstcount_d;
      addr_q <= addr_d;
      row_base_q <= row_base_d;
      stride_q <= stride_d;
      row_rem_q <= row_rem_d;
      rows_rem_q <= rows_rem_d;
      row_len_q <= row_len_d;
      rows_q <= rows_d;
      pending_q <= pending_d;
      rx_col_q <= rx_col_d;
      rx_row_q <= rx_row_d;
    end
endmodule

// File: tb/tb_npu_dma_rd2d.sv
// tb_npu_dma_rd2d: scoreboard bench with memory model, random bus timing and back-pressure
module tb_npu_dma_rd2d;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [31:0] cfg_addr, cfg_stride, m_address;
  logic [15:0] cfg_row_len, cfg_rows;
  logic start, abort, busy, done, aborted;
  logic m_waitrequest, m_readdatavalid, m_read;
  logic [63:0] m_readdata, out_data;
  logic [4:0] m_burstcount;
  logic out_valid, out_ready, out_row_last, out_last;
  npu_dma_rd2d dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows), .cfg_stride(cfg_stride),
    .start(start), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_last(out_row_last), .out_last(out_last)
  );
  typedef struct packed {logic [31:0] a; logic [4:0] n;} burst_t;
  burst_t exp_b[$];
  logic [65:0] exp_w[$];
  logic [31:0] beat_q[$];
  int errors = 0, checks = 0, cnt = 0, start_cnt = 0;
  int ready_mode = 1, grants = 0, granted_words = 0, reads_seen = 0, first_read = -1, last_grant = -100;
  bit wr_rand = 0, gap_rand = 0, hold = 0, prev_wait = 0;
  logic [31:0] prev_a;
  logic [4:0] prev_n;
  always @(posedge clk) cnt <= cnt + 1;
  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a * 32'h9E37_79B1};
  endfunction
  // memory slave: returns beats for accepted bursts, checks request ordering and stability
  always @(negedge clk) if (!rst) begin
    if (!hold && beat_q.size() > 0 && (!gap_rand || $urandom_range(0, 2) != 0)) begin
      m_readdatavalid = 1'b1;
      m_readdata = mem_word(beat_q.pop_front());
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata = {$urandom, $urandom};
    end
    m_waitrequest = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (prev_wait) check("req_stable", {m_read, m_address, m_burstcount}, {1'b1, prev_a, prev_n});
    else if (m_read) begin
      reads_seen++;
      if (first_read < 0) first_read = cnt;
      if (grants > 0) check("reissue_gap", 1'((cnt - last_grant) >= 2), 1'b1);
    end
    if (m_read && !m_waitrequest) begin
      grants++;
      granted_words += int'(m_burstcount);
      last_grant = cnt;
      for (int i = 0; i < int'(m_burstcount); i++) beat_q.push_back(m_address + 32'(i) * 8);
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL burst: unexpected burst %0d@%h", m_burstcount, m_address);
      end else check("burst", {m_address, m_burstcount}, exp_b.pop_front());
    end
    prev_wait = m_read && m_waitrequest;
    prev_a = m_address;
    prev_n = m_burstcount;
  end
  // stream sink: drives ready and compares every accepted word against the scoreboard
  always @(negedge clk) if (!rst) begin
    out_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    if (out_valid && out_ready) begin
      if (exp_w.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_word: unexpected word %h", {out_last, out_row_last, out_data});
      end else check("out_word", {out_last, out_row_last, out_data}, exp_w.pop_front());
    end
  end
  task automatic plan(input logic [31:0] a, input int len, input int rows, input logic [31:0] stride, input bit words);
    logic [31:0] base;
    for (int r = 0; r < rows; r++) begin
      base = a + stride * 32'(r);
      for (int off = 0; off < len; off += 16)
        exp_b.push_back({base + 32'(off) * 8, 5'((len - off < 16) ? len - off : 16)});
      if (words) for (int c = 0; c < len; c++)
        exp_w.push_back({1'(r == rows - 1 && c == len - 1), 1'(c == len - 1), mem_word(base + 32'(c) * 8)});
    end
  endtask
  task automatic kick(input logic [31:0] a, input int len, input int rows, input logic [31:0] stride);
    @(negedge clk);
    cfg_addr = a;
    cfg_row_len = 16'(len);
    cfg_rows = 16'(rows);
    cfg_stride = stride;
    start = 1'b1;
    first_read = -1;
    start_cnt = cnt;
  endtask
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done not seen within 20000 cycles");
    end
  endtask
  task automatic post(input logic exp_ab);
    check("aborted", aborted, exp_ab);
    check("busy_after_done", busy, 1'b0);
    check("words_left", 66'(exp_w.size()), 66'd0);
    check("bursts_left", 66'(exp_b.size()), 66'd0);
    check("beats_left", 66'(beat_q.size()), 66'd0);
  endtask
  initial begin
    int lat, g0, r0, w0, len, rows;
    logic [31:0] a, s;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_addr = '0;
    cfg_row_len = '0;
    cfg_rows = '0;
    cfg_stride = '0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, aborted, m_read, m_address, m_burstcount, out_valid, out_row_last, out_last}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", {busy, done, aborted, m_read, out_valid}, '0);
    plan(32'h1000, 40, 1, 32'h0, 1'b1);
    kick(32'h1000, 40, 1, 32'h0);
    wait_done(lat);
    check("first_read_latency", 66'(first_read - start_cnt), 66'd2);
    post(1'b0);
    plan(32'h0, 5, 3, 32'h200, 1'b1);
    kick(32'h0, 5, 3, 32'h200);
    wait_done(lat);
    post(1'b0);
    ready_mode = 0;
    w0 = granted_words;
    plan(32'h8000, 200, 1, 32'h0, 1'b1);
    kick(32'h8000, 200, 1, 32'h0);
    repeat (300) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("backpressure_words", 66'(granted_words - w0), 66'd64);
    check("backpressure_valid", out_valid, 1'b1);
    ready_mode = 1;
    wait_done(lat);
    post(1'b0);
    wr_rand = 1;
    gap_rand = 1;
    ready_mode = 2;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 40);
      rows = $urandom_range(1, 4);
      a = $urandom & 32'hFFFF_FFF8;
      s = 32'(len) * 8 + 32'($urandom_range(0, 4)) * 8;
      plan(a, len, rows, s, 1'b1);
      kick(a, len, rows, s);
      wait_done(lat);
      post(1'b0);
    end
    wr_rand = 0;
    gap_rand = 0;
    ready_mode = 0;
    hold = 1;
    g0 = grants;
    plan(32'h4000, 64, 1, 32'h0, 1'b0);
    kick(32'h4000, 64, 1, 32'h0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (grants >= g0 + 2) break;
    end
    abort = 1'b1;
    r0 = reads_seen;
    @(negedge clk);
    abort = 1'b0;
    hold = 0;
    wait_done(lat);
    check("abort_grants", 66'(grants - g0), 66'd2);
    check("abort_no_new_read", 66'(reads_seen - r0), 66'd0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_bursts_skipped", 66'(exp_b.size()), 66'd2);
    exp_b.delete();
    post(1'b1);
    ready_mode = 1;
    r0 = reads_seen;
    kick(32'h100, 5, 0, 32'h0);
    wait_done(lat);
    check("zero_done_latency", 66'(lat), 66'd2);
    check("zero_no_read", 66'(reads_seen - r0), 66'd0);
    post(1'b0);
    plan(32'hFFFF_FFF8, 2, 1, 32'h10, 1'b1);
    kick(32'hFFFF_FFF8, 2, 1, 32'h10);
    wait_done(lat);
    check("wrap_address", m_address, 32'h8);
    post(1'b0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
